alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational RV32 integer ALU between N_REQ requesters, e.g. the execute stage and the branch-compare/address unit.
- Arbitrates round-robin and registers the selected operation into the ALU operand/opcode inputs.
- Captures the ALU result and returns it to the granted requester over a valid/ready response channel.
- Sits between the requesters and the ALU instance.

Parameters:
- DATA_WIDTH, 32, width of operands and result.
- N_REQ, 2, number of requesters (2..8).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester request accept; at most one bit set.
- req_func3  input  3*N_REQ  per-requester func3, requester i at [3i+2:3i].
- req_func7  input  7*N_REQ  per-requester func7, packed the same way.
- req_rs1  input  DATA_WIDTH*N_REQ  per-requester operand 1.
- req_rs2  input  DATA_WIDTH*N_REQ  per-requester operand 2.
- resp_valid  output  N_REQ  per-requester result valid; at most one bit set.
- resp_ready  input  N_REQ  per-requester result accept.
- resp_data  output  DATA_WIDTH  result, shared by all requesters; qualified by resp_valid.
- resp_err  output  1  illegal-opcode flag, qualified by resp_valid.
- alu_func3  output  3  to ALU.
- alu_func7  output  7  to ALU.
- alu_rs1  output  DATA_WIDTH  to ALU.
- alu_rs2  output  DATA_WIDTH  to ALU.
- alu_rd  input  DATA_WIDTH  ALU result, combinational from alu_* outputs.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, all req_ready=0, all resp_valid=0.
  - resp_data=0, resp_err=0, alu_* outputs=0.
  - Last-grant pointer=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from (last_grant+1) mod N_REQ upward, with wrap-around.
  - Assert req_ready for that bit only, combinationally, in the same cycle.
  - On the edge: latch that requester's func3/func7/rs1/rs2 into the alu_* registers, record the grant index, go to EXEC.
  - If no req_valid is set: stay in IDLE, req_ready=0.
- EXEC (1 cycle):
  - ALU evaluates from the registered operands.
  - On the edge: capture alu_rd into resp_data, go to RESP.
- RESP:
  - resp_valid[grant]=1; resp_data and resp_err are held stable.
  - When resp_ready[grant]=1: on the edge, drop resp_valid, set last_grant=grant, go to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
  - No new request is accepted while in RESP.
- Latency and throughput:
  - Request handshake in cycle T gives resp_valid in cycle T+2.
  - Peak throughput is one operation per 3 cycles.
- Requester rules:
  - Once req_valid is asserted, it stays asserted with stable fields until the req_ready handshake. No withdrawal.
  - Ignoring this is a protocol violation; the arbiter behaviour is then undefined.
- Fairness: two requesters continuously valid alternate grants (0,1,0,1…). With N_REQ requesters all valid, each is served once every N_REQ operations.
- alu_* outputs hold the last operation after RESP; they change only on an IDLE acceptance.
- Opcode legality: func7 in {0000000, 0100000}, and if func7=0100000 then func3 in {000, 101}. Anything else is illegal.
- Width: resp_data is exactly DATA_WIDTH bits; no extension or truncation is applied to alu_rd.
- Reset mid-operation (any state): the in-flight operation is dropped with no response, and the pointer returns to N_REQ-1.

Optional Feature:
- Macro ALU_ARB_ILLEGAL_CHECK_EN.
- Defined: an illegal opcode is still sequenced through EXEC/RESP, but resp_data=0 and resp_err=1 for that response. Legal opcodes give resp_err=0.
- Undefined: no decode. func3/func7 pass unchanged to the ALU, resp_data=alu_rd, and resp_err is tied to 0.
- Cycle timing is identical in both builds.

Test Plan:
- Reset then single op:
  - Stimulus: req0 valid, func7=0000000, func3=000, rs1=5, rs2=7, resp_ready0=1.
  - Response: req_ready0 in the same cycle; resp_valid0 two cycles later with resp_data=12; back in IDLE on the next cycle.
- Contention:
  - Stimulus: req0 and req1 both held valid for 4 operations (SUB 10-3, XOR F0^0F).
  - Response: grant order 0,1,0,1; results 7 and 0xFF delivered to the correct requester; resp_valid never set for both.
- Backpressure:
  - Stimulus: resp_ready0=0 for 5 cycles after resp_valid0 rises, with req1 valid throughout.
  - Response: resp_data stable for all 5 cycles, req_ready1=0 throughout; req1 granted on the cycle after resp_ready0 goes high.
- Async reset in EXEC:
  - Stimulus: drop rst_n in the cycle after req1 is accepted.
  - Response: all outputs 0 immediately. After release, with both valid, req0 is granted first.
- Illegal opcode:
  - Stimulus: func7=0100000, func3=100.
  - Response with ALU_ARB_ILLEGAL_CHECK_EN: resp_err=1, resp_data=0.
  - Response without: resp_err=0, resp_data=alu_rd.
- Wrap-around with N_REQ=3:
  - Stimulus: last grant=2, req0 and req2 valid.
  - Response: req0 granted next.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational RV32 ALU between N_REQ requesters.
// Optional build macro ALU_ARB_ILLEGAL_CHECK_EN zeroes the result and flags resp_err_o for illegal opcodes.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_REQ      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic [3*N_REQ-1:0]            req_func3_i,
  input  logic [7*N_REQ-1:0]            req_func7_i,
  input  logic [DATA_WIDTH*N_REQ-1:0]   req_rs1_i,
  input  logic [DATA_WIDTH*N_REQ-1:0]   req_rs2_i,
  output logic [N_REQ-1:0]              resp_valid_o,
  input  logic [N_REQ-1:0]              resp_ready_i,
  output logic [DATA_WIDTH-1:0]         resp_data_o,
  output logic                          resp_err_o,
  output logic [2:0]                    alu_func3_o,
  output logic [6:0]                    alu_func7_o,
  output logic [DATA_WIDTH-1:0]         alu_rs1_o,
  output logic [DATA_WIDTH-1:0]         alu_rs2_o,
  input  logic [DATA_WIDTH-1:0]         alu_rd_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [2:0]            alu_func3_q, alu_func3_d;
  logic [6:0]            alu_func7_q, alu_func7_d;
  logic [DATA_WIDTH-1:0] alu_rs1_q, alu_rs1_d;
  logic [DATA_WIDTH-1:0] alu_rs2_q, alu_rs2_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [N_REQ-1:0]      resp_valid_q, resp_valid_d;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic [2:0]            sel_func3;
  logic [6:0]            sel_func7;
  logic [DATA_WIDTH-1:0] sel_rs1;
  logic [DATA_WIDTH-1:0] sel_rs2;

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
  logic resp_err_q, resp_err_d;
  logic illegal_c;

  // Only ADD..AND with func7=0, plus SUB and SRA, are legal RV32 ALU ops.
  assign illegal_c = !((alu_func7_q == 7'b0000000) ||
                       ((alu_func7_q == 7'b0100000) &&
                        ((alu_func3_q == 3'b000) || (alu_func3_q == 3'b101))));
  assign resp_err_o = resp_err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  // Round-robin search starting just after the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = '0;
    sel_func3  = '0;
    sel_func7  = '0;
    sel_rs1    = '0;
    sel_rs2    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_func3 = req_func3_i[3*i +: 3];
        sel_func7 = req_func7_i[7*i +: 7];
        sel_rs1   = req_rs1_i[DATA_WIDTH*i +: DATA_WIDTH];
        sel_rs2   = req_rs2_i[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // Next-state and handshake logic; req_ready_o is held low while reset is asserted.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    alu_func3_d  = alu_func3_q;
    alu_func7_d  = alu_func7_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    req_ready_o  = '0;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found && rst_n) begin
          req_ready_o[pick_idx] = 1'b1;
          grant_d     = pick_idx;
          alu_func3_d = sel_func3;
          alu_func7_d = sel_func7;
          alu_rs1_d   = sel_rs1;
          alu_rs2_d   = sel_rs2;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
        resp_data_d = illegal_c ? '0 : alu_rd_i;
        resp_err_d  = illegal_c;
`else
        resp_data_d = alu_rd_i;
`endif
        resp_valid_d          = '0;
        resp_valid_d[grant_q] = 1'b1;
        state_d               = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i[grant_q]) begin
          resp_valid_d = '0;
          last_d       = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        resp_valid_d = '0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= IDX_W'(N_REQ - 1);
      grant_q      <= '0;
      alu_func3_q  <= '0;
      alu_func7_q  <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      alu_func3_q  <= alu_func3_d;
      alu_func7_q  <= alu_func7_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign alu_func3_o  = alu_func3_q;
  assign alu_func7_o  = alu_func7_q;
  assign alu_rs1_o    = alu_rs1_q;
  assign alu_rs2_o    = alu_rs2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter (N_REQ=3): directed scenarios then random traffic vs a transaction-level model.
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned N  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_func3;
  logic [7*N-1:0]  req_func7;
  logic [DW*N-1:0] req_rs1;
  logic [DW*N-1:0] req_rs2;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_data;
  logic            resp_err;
  logic [2:0]      alu_func3;
  logic [6:0]      alu_func7;
  logic [DW-1:0]   alu_rs1;
  logic [DW-1:0]   alu_rs2;
  logic [DW-1:0]   alu_rd;

  typedef struct {
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  alu_share_arbiter #(.DATA_WIDTH(DW), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_func3_i(req_func3), .req_func7_i(req_func7),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_err_o(resp_err),
    .alu_func3_o(alu_func3), .alu_func7_o(alu_func7),
    .alu_rs1_o(alu_rs1), .alu_rs2_o(alu_rs2),
    .alu_rd_i(alu_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f3)
      3'd0:    return f7[5] ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return {31'b0, $signed(a) < $signed(b)};
      3'd3:    return {31'b0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return f7[5] ? DW'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_rd = alu_f(alu_func3, alu_func7, alu_rs1, alu_rs2);

  function automatic bit legal(input op_t o);
    return (o.f7 == 7'h00) || (o.f7 == 7'h20 && (o.f3 == 3'd0 || o.f3 == 3'd5));
  endfunction

  // Transaction-level reference state
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            busy;
  int            g_req;
  int            acc_cyc;
  int            last_g;
  op_t           last_op;
  logic [DW-1:0] exp_data;
  logic          exp_err;
  int            hold_cnt[N];
  bit            rand_mode = 1'b0;
  int            gh[$];

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic op_t req_op(input int i);
    op_t o;
    o.f3 = req_func3[3*i +: 3];
    o.f7 = req_func7[7*i +: 7];
    o.a  = req_rs1[DW*i +: DW];
    o.b  = req_rs2[DW*i +: DW];
    return o;
  endfunction

  task automatic set_req(input int i, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    req_valid[i]         = 1'b1;
    req_func3[3*i +: 3]  = f3;
    req_func7[7*i +: 7]  = f7;
    req_rs1[DW*i +: DW]  = a;
    req_rs2[DW*i +: DW]  = b;
    hold_cnt[i]          = hold;
  endtask

  task automatic rand_req(input int i);
    int r;
    logic [6:0] f7;
    r  = $urandom_range(0, 9);
    f7 = (r < 5) ? 7'h00 : (r < 9) ? 7'h20 : 7'($urandom);
    set_req(i, f7, 3'($urandom), $urandom, $urandom, 0);
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_g + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    busy    = 1'b0;
    last_g  = N - 1;
    last_op = '{default: '0};
  endfunction

  // One clock cycle: check outputs mid-cycle, advance the model, then update stimulus.
  task automatic step();
    int p;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    op_t o;
    @(negedge clk);
    exp_rdy = '0;
    exp_rv  = '0;
    p = busy ? -1 : rr_pick();
    if (p >= 0) exp_rdy[p] = 1'b1;
    if (busy && cyc >= acc_cyc + 2) exp_rv[g_req] = 1'b1;
    chk("req_ready", 96'(req_ready), 96'(exp_rdy));
    chk("resp_valid", 96'(resp_valid), 96'(exp_rv));
    if (exp_rv != '0) begin
      chk("resp_data", 96'(resp_data), 96'(exp_data));
      chk("resp_err", 96'(resp_err), 96'(exp_err));
    end
    chk("alu_op", 96'({alu_func7, alu_func3, alu_rs1, alu_rs2}),
        96'({last_op.f7, last_op.f3, last_op.a, last_op.b}));
    if (exp_rv != '0 && resp_ready[g_req]) begin
      busy   = 1'b0;
      last_g = g_req;
    end
    if (p >= 0) begin
      o       = req_op(p);
      busy    = 1'b1;
      g_req   = p;
      acc_cyc = cyc;
      last_op = o;
      gh.push_back(p);
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
      exp_err  = !legal(o);
      exp_data = legal(o) ? alu_f(o.f3, o.f7, o.a, o.b) : '0;
`else
      exp_err  = 1'b0;
      exp_data = alu_f(o.f3, o.f7, o.a, o.b);
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
    if (p >= 0) begin
      if (hold_cnt[p] > 0) hold_cnt[p]--;
      else if (rand_mode && $urandom_range(0, 1) == 1) rand_req(p);
      else req_valid[p] = 1'b0;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
      resp_ready = N'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 96'(req_ready), 96'(0));
    chk("rst_resp_valid", 96'(resp_valid), 96'(0));
    chk("rst_resp_data", 96'(resp_data), 96'(0));
    chk("rst_resp_err", 96'(resp_err), 96'(0));
    chk("rst_alu", 96'({alu_func7, alu_func3, alu_rs1, alu_rs2}), 96'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n      = 1'b1;
    req_valid  = '0;
    req_func3  = '0;
    req_func7  = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    resp_ready = '0;
    for (int i = 0; i < N; i++) hold_cnt[i] = 0;
    model_reset();
    #2;
    do_reset();

    // Single ADD 5+7 from requester 0
    resp_ready = '1;
    set_req(0, 7'h00, 3'd0, 32'd5, 32'd7, 0);
    repeat (2) step();
    chk("add_valid", 96'(resp_valid), 96'(3'b001));
    chk("add_result", 96'(resp_data), 96'(32'd12));
    repeat (2) step();

    // Illegal opcode: func7=0100000, func3=100
    set_req(0, 7'h20, 3'd4, 32'h0000_1234, 32'h0000_0F0F, 0);
    repeat (2) step();
`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    chk("illegal_err", 96'(resp_err), 96'(1));
    chk("illegal_data", 96'(resp_data), 96'(0));
`else
    chk("illegal_err", 96'(resp_err), 96'(0));
    chk("illegal_data", 96'(resp_data), 96'(32'h0000_1234 ^ 32'h0000_0F0F));
`endif
    step();

    // Wrap-around: serve requester 2, then 0 and 2 contend
    set_req(2, 7'h00, 3'd6, 32'h00F0_0000, 32'h0000_000F, 0);
    repeat (3) step();
    set_req(0, 7'h00, 3'd7, 32'hFFFF_0000, 32'h1234_5678, 0);
    set_req(2, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 0);
    step();
    chk("wrap_grant", 96'(gh[gh.size()-1]), 96'(0));
    repeat (5) step();

    // Backpressure on requester 0 while requester 1 waits
    resp_ready = '0;
    set_req(0, 7'h00, 3'd3, 32'd1, 32'hFFFF_FFFF, 0);
    set_req(1, 7'h00, 3'd1, 32'h0000_0003, 32'd8, 0);
    repeat (7) step();
    resp_ready[0] = 1'b1;
    repeat (2) step();
    chk("bp_next_grant", 96'(gh[gh.size()-1]), 96'(1));
    resp_ready = '1;
    repeat (2) step();

    // Reset while requester 1 is in EXEC, then 0/1 contention
    set_req(1, 7'h00, 3'd0, 32'd100, 32'd200, 0);
    step();
    set_req(0, 7'h20, 3'd0, 32'd10, 32'd3, 1);
    set_req(1, 7'h00, 3'd4, 32'h0000_00F0, 32'h0000_000F, 1);
    do_reset();
    base = gh.size();
    repeat (12) step();
    for (int k = 0; k < 4; k++)
      chk("contention_grant", 96'(gh[base+k]), 96'(k % 2));
    repeat (2) step();

    // Random traffic
    rand_mode = 1'b1;
    repeat (400) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
